// File: rtl/ysyx_25030093_pkg.sv
// Shared definitions for the writeback unit: load format codes, default
// datapath widths and the writeback FIFO entry layout.
package ysyx_25030093_pkg;

    localparam int WBU_ADDR_WIDTH = 5;
    localparam int WBU_DATA_WIDTH = 32;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    // One buffered result; data is already load-formatted.
    typedef struct packed {
        logic [WBU_DATA_WIDTH-1:0] pc;
        logic [WBU_ADDR_WIDTH-1:0] rd;
        logic                      wen;
        logic [WBU_DATA_WIDTH-1:0] data;
    } wbu_entry_t;

endpackage

// File: rtl/ysyx_25030093_ld_fmt.sv
// Combinational load extractor: picks the byte/half/word addressed by
// addr_lo out of an aligned memory word, sign- or zero-extends it, and flags
// misaligned half/word accesses. Undefined format codes yield zero data.
module ysyx_25030093_ld_fmt
    import ysyx_25030093_pkg::*;
(
    input  logic [2:0]                fmt,
    input  logic [1:0]                addr_lo,
    input  logic [WBU_DATA_WIDTH-1:0] rdata,
    output logic [WBU_DATA_WIDTH-1:0] data,
    output logic                      misalign
);

    logic [WBU_DATA_WIDTH-1:0] shifted;

    // Align the addressed lane down to bit 0, then extend per format.
    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        data     = '0;
        misalign = 1'b0;
        case (fmt)
            LD_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
            LD_LBU: data = {24'h0, shifted[7:0]};
            LD_LH: begin
                data     = {{16{shifted[15]}}, shifted[15:0]};
                misalign = addr_lo[0];
            end
            LD_LHU: begin
                data     = {16'h0, shifted[15:0]};
                misalign = addr_lo[0];
            end
            LD_LW: begin
                // Equals rdata when aligned; a misaligned word never writes.
                data     = shifted;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                data     = '0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: buffers EXU/LSU results in a small FIFO (load data is
// formatted on entry), drives the register-file write port and a commit pulse,
// and keeps per-register pending-write counters for IDU hazard detection.
// Optional macro WBU_BYPASS_EN adds a two-port forwarding path off the
// registered write port.
module ysyx_25030093_wbu
    import ysyx_25030093_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int ADDR_WIDTH   = WBU_ADDR_WIDTH,
    parameter int DATA_WIDTH   = WBU_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_valid,
    input  logic                    iss_wen,
    input  logic [ADDR_WIDTH-1:0]   iss_rd,
    output logic                    iss_ready,
    output logic [2**ADDR_WIDTH-1:0] busy_vec,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_pc,
    input  logic [ADDR_WIDTH-1:0]   in_rd,
    input  logic                    in_wen,
    input  logic                    in_is_load,
    input  logic [2:0]              in_ld_fmt,
    input  logic [1:0]              in_addr_lo,
    input  logic [DATA_WIDTH-1:0]   in_alu_res,
    input  logic [DATA_WIDTH-1:0]   in_mem_rdata,
    input  logic                    wb_stall,
`ifdef WBU_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0]   byp_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]   byp_rs2_addr,
    output logic                    byp_rs1_hit,
    output logic [DATA_WIDTH-1:0]   byp_rs1_data,
    output logic                    byp_rs2_hit,
    output logic [DATA_WIDTH-1:0]   byp_rs2_data,
`endif
    output logic                    rf_wen,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    output logic                    commit_valid,
    output logic [DATA_WIDTH-1:0]   commit_pc,
    output logic                    misalign_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int NREG  = 2 ** ADDR_WIDTH;

    // FIFO storage; dec_mem marks entries whose rd counter must be released
    // on retirement (original wen, before misalignment suppression).
    wbu_entry_t             mem_q [DEPTH];
    wbu_entry_t             mem_d [DEPTH];
    logic [DEPTH-1:0]       dec_mem_q, dec_mem_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;

    logic                   rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic                   commit_valid_q, commit_valid_d;
    logic [DATA_WIDTH-1:0]  commit_pc_q, commit_pc_d;
    logic                   dec_out_q, dec_out_d;

    logic [CNT_W-1:0]       cnt_q [NREG];
    logic [CNT_W-1:0]       cnt_d [NREG];

    logic                   full, empty, enq, deq, iss_fire;
    logic [DATA_WIDTH-1:0]  fmt_data;
    logic                   fmt_misalign;
    wbu_entry_t             new_entry, head;

    ysyx_25030093_ld_fmt u_ld_fmt (
        .fmt      (in_ld_fmt),
        .addr_lo  (in_addr_lo),
        .rdata    (in_mem_rdata),
        .data     (fmt_data),
        .misalign (fmt_misalign)
    );

    // FIFO status, handshakes and the entry to be written.
    always_comb begin
        empty          = (wptr_q == rptr_q);
        full           = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                         (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
        in_ready       = ~full;
        enq            = in_valid & ~full;
        deq            = ~empty & ~wb_stall;
        misalign_err   = enq & in_is_load & fmt_misalign;
        new_entry.pc   = in_pc;
        new_entry.rd   = in_rd;
        new_entry.wen  = in_wen & ~(in_is_load & fmt_misalign);
        new_entry.data = in_is_load ? fmt_data : in_alu_res;
        head           = mem_q[rptr_q[IDX_W-1:0]];
    end

    // Next state of FIFO storage, pointers and the registered write port.
    always_comb begin
        mem_d     = mem_q;
        dec_mem_d = dec_mem_q;
        wptr_d    = wptr_q + PTR_W'(enq);
        rptr_d    = rptr_q + PTR_W'(deq);
        if (enq) begin
            mem_d[wptr_q[IDX_W-1:0]]     = new_entry;
            dec_mem_d[wptr_q[IDX_W-1:0]] = in_wen & (in_rd != '0);
        end
        rf_wen_d       = 1'b0;
        commit_valid_d = deq;
        dec_out_d      = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_pc_d    = commit_pc_q;
        if (deq) begin
            rf_wen_d    = head.wen & (head.rd != '0);
            rf_waddr_d  = head.rd;
            rf_wdata_d  = head.data;
            commit_pc_d = head.pc;
            dec_out_d   = dec_mem_q[rptr_q[IDX_W-1:0]];
        end
    end

    // Scoreboard: increments on issue, decrements when the write retires;
    // simultaneous increment and decrement cancel. x0 is never counted.
    always_comb begin
        iss_ready = ~(iss_wen & (cnt_q[iss_rd] == CNT_W'(MAX_INFLIGHT)));
        iss_fire  = iss_valid & iss_ready & iss_wen & (iss_rd != '0);
        cnt_d     = cnt_q;
        busy_vec  = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (iss_fire && (iss_rd == ADDR_WIDTH'(i)) &&
                !(dec_out_q && (rf_waddr_q == ADDR_WIDTH'(i)))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_out_q && (rf_waddr_q == ADDR_WIDTH'(i)) &&
                         !(iss_fire && (iss_rd == ADDR_WIDTH'(i))) &&
                         (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            busy_vec[i] = (cnt_q[i] != '0);
        end
        cnt_d[0] = '0;
    end

    // State registers; reset discards all buffered entries and counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
            dec_mem_q      <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            dec_out_q      <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            cnt_q          <= cnt_d;
            dec_mem_q      <= dec_mem_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            dec_out_q      <= dec_out_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;

`ifdef WBU_BYPASS_EN
    // Forward the write currently on the register-file port to IDU.
    assign byp_rs1_hit  = rf_wen_q & (rf_waddr_q == byp_rs1_addr) & (byp_rs1_addr != '0);
    assign byp_rs2_hit  = rf_wen_q & (rf_waddr_q == byp_rs2_addr) & (byp_rs2_addr != '0);
    assign byp_rs1_data = rf_wdata_q;
    assign byp_rs2_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Scoreboard bench for the writeback unit: directed cases from the block's
// test plan followed by randomized issue/complete traffic.
module tb_ysyx_25030093_wbu;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int MAXI  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          iss_valid, iss_wen, iss_ready;
    logic [AW-1:0] iss_rd;
    logic [31:0]   busy_vec;
    logic          in_valid, in_ready, in_wen, in_is_load, wb_stall;
    logic [DW-1:0] in_pc, in_alu_res, in_mem_rdata;
    logic [AW-1:0] in_rd;
    logic [2:0]    in_ld_fmt;
    logic [1:0]    in_addr_lo;
    logic          rf_wen, commit_valid, misalign_err;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, commit_pc;
`ifdef WBU_BYPASS_EN
    logic [AW-1:0] byp_rs1_addr, byp_rs2_addr;
    logic          byp_rs1_hit, byp_rs2_hit;
    logic [DW-1:0] byp_rs1_data, byp_rs2_data;
`endif

    ysyx_25030093_wbu #(
        .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
        .iss_ready(iss_ready), .busy_vec(busy_vec),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_wen(in_wen), .in_is_load(in_is_load), .in_ld_fmt(in_ld_fmt),
        .in_addr_lo(in_addr_lo), .in_alu_res(in_alu_res),
        .in_mem_rdata(in_mem_rdata), .wb_stall(wb_stall),
`ifdef WBU_BYPASS_EN
        .byp_rs1_addr(byp_rs1_addr), .byp_rs2_addr(byp_rs2_addr),
        .byp_rs1_hit(byp_rs1_hit), .byp_rs1_data(byp_rs1_data),
        .byp_rs2_hit(byp_rs2_hit), .byp_rs2_data(byp_rs2_data),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .misalign_err(misalign_err)
    );

    typedef struct { logic [31:0] pc; logic wen; logic [4:0] rd; logic [31:0] data; } exp_t;
    typedef struct { logic [4:0] rd; logic dec; } mf_t;
    typedef struct { logic [4:0] rd; logic wen; } pend_t;

    exp_t  sb_q[$];     // expected commits, in order
    mf_t   mf_q[$];     // model of buffered entries (occupancy + release info)
    pend_t pend_q[$];   // issued instructions not yet completed
    int    cnt [32];    // model pending-write counts
    bit    or_v, or_dec;
    logic [4:0] or_rd;
    int    checks = 0;
    int    errors = 0;
    logic [31:0] pc_ctr = 32'h8000_0000;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Loads from the rules: select the lane by byte offset, extend by format.
    function automatic logic [31:0] ref_load(logic [2:0] fmt, logic [1:0] lo, logic [31:0] w);
        longint unsigned wl, b, h, v;
        wl = 64'(w);
        b  = (wl >> (8 * lo)) % 256;
        h  = (wl >> (8 * lo)) % 65536;
        case (fmt)
            3'd0:    v = (b >= 128) ? b + 64'hFFFF_FF00 : b;
            3'd4:    v = b;
            3'd1:    v = (h >= 32768) ? h + 64'hFFFF_0000 : h;
            3'd5:    v = h;
            3'd2:    v = wl;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bit ref_mis(logic [2:0] fmt, logic [1:0] lo);
        return ((fmt == 3'd1 || fmt == 3'd5) && (lo % 2 == 1)) || (fmt == 3'd2 && lo != 0);
    endfunction

    task automatic set_idle();
        iss_valid = 0; iss_wen = 0; iss_rd = 0;
        in_valid = 0; in_wen = 0; in_rd = 0; in_is_load = 0; in_ld_fmt = 0;
        in_addr_lo = 0; in_alu_res = 0; in_mem_rdata = 0; in_pc = 0;
    endtask

    // One clock: check combinational outputs, record accepted work, advance
    // the model across the edge and check the pending-write vector.
    task automatic step(output bit acc, output bit acc_iss);
        bit mis_e;
        exp_t e;
        mf_t m;
        logic [31:0] ev;
        #1;
        acc     = in_valid && (mf_q.size() < DEPTH);
        acc_iss = iss_valid && !(iss_wen && cnt[iss_rd] == MAXI);
        chk("in_ready", in_ready, mf_q.size() < DEPTH);
        chk("iss_ready", iss_ready, !(iss_wen && cnt[iss_rd] == MAXI));
        mis_e = acc && in_is_load && ref_mis(in_ld_fmt, in_addr_lo);
        chk("misalign_err", misalign_err, mis_e);
        if (acc) begin
            e.pc   = in_pc;
            e.rd   = in_rd;
            e.wen  = in_wen && !mis_e && (in_rd != 0);
            e.data = in_is_load ? ref_load(in_ld_fmt, in_addr_lo, in_mem_rdata) : in_alu_res;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (or_v && or_dec) cnt[or_rd]--;
        if (acc_iss && iss_wen && iss_rd != 0) cnt[iss_rd]++;
        if (mf_q.size() > 0 && !wb_stall) begin
            m = mf_q.pop_front();
            or_v = 1; or_dec = m.dec; or_rd = m.rd;
        end else begin
            or_v = 0;
        end
        if (acc) begin
            m.rd = in_rd; m.dec = in_wen && (in_rd != 0);
            mf_q.push_back(m);
        end
        #1;
        for (int i = 0; i < 32; i++) ev[i] = (cnt[i] != 0);
        chk("busy_vec", busy_vec, ev);
    endtask

    task automatic issue(input logic [4:0] rd);
        bit a, b;
        set_idle();
        iss_valid = 1; iss_wen = 1; iss_rd = rd;
        step(a, b);
    endtask

    task automatic enq(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [2:0] fmt, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] mem, output bit acc);
        bit b;
        set_idle();
        in_valid = 1; in_pc = pc; in_rd = rd; in_wen = wen; in_is_load = ld;
        in_ld_fmt = fmt; in_addr_lo = lo; in_alu_res = alu; in_mem_rdata = mem;
        step(acc, b);
    endtask

    task automatic idle_n(input int n);
        bit a, b;
        for (int i = 0; i < n; i++) begin
            set_idle();
            step(a, b);
        end
    endtask

    // Monitor: every commit pulse pops and checks the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
`ifdef WBU_BYPASS_EN
            byp_rs1_addr = AW'($urandom % 8);
            byp_rs2_addr = AW'($urandom % 32);
`endif
            #1;
            if (rst_n === 1'b1) begin
                if (commit_valid === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_commit", commit_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("commit_pc", commit_pc, e.pc);
                        chk("rf_wen", rf_wen, e.wen);
                        if (e.wen) begin
                            chk("rf_waddr", rf_waddr, e.rd);
                            chk("rf_wdata", rf_wdata, e.data);
                        end
`ifdef WBU_BYPASS_EN
                        chk("byp_rs1_hit", byp_rs1_hit, e.wen && e.rd == byp_rs1_addr && byp_rs1_addr != 0);
                        chk("byp_rs2_hit", byp_rs2_hit, e.wen && e.rd == byp_rs2_addr && byp_rs2_addr != 0);
                        if (e.wen) chk("byp_rs1_data", byp_rs1_data, e.data);
`endif
                    end
                end else begin
                    chk("rf_wen_idle", rf_wen, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc, acc_iss, done;
        logic [2:0] fmts [7];
        pend_t p;
        fmts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        or_v = 0; or_dec = 0; or_rd = 0;

        // Reset values
        rst_n = 0; wb_stall = 0;
        set_idle();
        #23;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_commit_pc", commit_pc, 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1;

        // LB / LBU from the top byte: two cycles from enqueue to rf_wen
        issue(5);
        enq(32'h100, 5, 1, 1, 3'd0, 2'd3, 0, 32'h8012_3456, acc);
        idle_n(1);
        chk("lb_rf_wen", rf_wen, 1);
        chk("lb_waddr", rf_waddr, 5);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        issue(5);
        enq(32'h104, 5, 1, 1, 3'd4, 2'd3, 0, 32'h8012_3456, acc);
        idle_n(1);
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        idle_n(2);

        // Fill under stall, third entry refused, then in-order drain
        wb_stall = 1;
        issue(7); issue(7);
        enq(32'h200, 7, 1, 0, 0, 0, 32'hAAAA_0001, 0, acc);
        enq(32'h204, 7, 1, 0, 0, 0, 32'hAAAA_0002, 0, acc);
        enq(32'h208, 0, 0, 0, 0, 0, 32'hAAAA_0003, 0, acc);
        chk("fill_third_refused", in_ready, 0);
        wb_stall = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            enq(32'h208, 0, 0, 0, 0, 0, 32'hAAAA_0003, 0, acc);
            done = acc;
        end
        chk("fill_retry_timeout", done, 1);
        idle_n(4);

        // Same-cycle increment and decrement on x9; issue to x0 ignored
        issue(9);
        enq(32'h300, 9, 1, 0, 0, 0, 32'h1234_5678, 0, acc);
        idle_n(1);
        issue(9);
        chk("busy9_hold", busy_vec[9], 1);
        issue(0);
        p.rd = 9; p.wen = 1; pend_q.push_back(p);

        // Misaligned LW still commits and releases its counter
        issue(12);
        enq(32'h400, 12, 1, 1, 3'd2, 2'd2, 0, 32'hDEAD_BEEF, acc);
        idle_n(3);
        chk("lw_mis_busy12", busy_vec[12], 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            wb_stall  = ($urandom % 4 == 0);
            iss_valid = $urandom % 2;
            iss_wen   = ($urandom % 5 != 0);
            iss_rd    = ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom % 32);
            if (pend_q.size() > 0 && $urandom % 3 != 0) begin
                in_valid     = 1;
                in_rd        = pend_q[0].rd;
                in_wen       = pend_q[0].wen;
                in_is_load   = $urandom % 2;
                in_ld_fmt    = fmts[$urandom % 7];
                in_addr_lo   = 2'($urandom % 4);
                in_alu_res   = $urandom;
                in_mem_rdata = $urandom;
                in_pc        = pc_ctr;
            end
            step(acc, acc_iss);
            if (acc) begin
                void'(pend_q.pop_front());
                pc_ctr += 4;
            end
            if (acc_iss) begin
                p.rd = iss_rd; p.wen = iss_wen; pend_q.push_back(p);
            end
        end

        // Drain everything outstanding
        wb_stall = 0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            set_idle();
            if (pend_q.size() > 0) begin
                in_valid = 1; in_rd = pend_q[0].rd; in_wen = pend_q[0].wen;
                in_alu_res = $urandom; in_pc = pc_ctr;
            end
            step(acc, acc_iss);
            if (acc) begin
                void'(pend_q.pop_front());
                pc_ctr += 4;
            end
            done = (pend_q.size() == 0 && mf_q.size() == 0 && !or_v);
        end
        chk("drain_timeout", done, 1);
        chk("busy_after_drain", busy_vec, 0);

        // Reset with two buffered entries and cnt[3]=2
        wb_stall = 1;
        issue(3); issue(3);
        enq(32'h500, 3, 1, 0, 0, 0, 32'h5555_0001, 0, acc);
        enq(32'h504, 3, 1, 0, 0, 0, 32'h5555_0002, 0, acc);
        chk("pre_reset_busy3", busy_vec[3], 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_busy_vec", busy_vec, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_rf_wen", rf_wen, 0);
        chk("mid_rst_commit", commit_valid, 0);
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        mf_q.delete(); sb_q.delete(); pend_q.delete();
        or_v = 0;
        @(negedge clk);
        rst_n = 1;
        wb_stall = 0;
        for (int i = 0; i < 6; i++) begin
            idle_n(1);
            chk("post_rst_rf_wen", rf_wen, 0);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
